read_logic: RTL and testbench

- Read-side pointer and flag controller of the asynchronous FIFO; the downstream counterpart of the write-side controller.
- Runs in the read clock domain.
- Accepts pop requests and issues the read address and read enable to the dual-port RAM.
- Maintains the binary read pointer exported to the write domain, and derives empty, occupancy and underflow from the write pointer after synchronisation into the read domain.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ptr_cmp.sv | 16 +
 rtl/read_logic.sv | 131 +++++++++++++
 tb/tb_read_logic.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: FSM state encodings, pointer width helper, default sizes.
package fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH = 7;
  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    HOLD   = 2'b11
  } fifo_state_e;

  // Pointers carry one extra wrap bit beyond the address.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_cmp.sv
// Pointer comparator: empty/full match and occupancy difference against a synchronised pointer.
module fifo_ptr_cmp
  import fifo_pkg::*;
#(
  parameter int unsigned PW = ptr_width(DEFAULT_DEPTH)
) (
  input  logic [PW-1:0] ptr_i,
  input  logic [PW-1:0] sync_ptr_i,
  output logic          match_c_o,
  output logic [PW-1:0] diff_c_o
);

  assign match_c_o = (ptr_i == sync_ptr_i);
  assign diff_c_o  = sync_ptr_i - ptr_i;

endmodule

// File: rtl/read_logic.sv
// Read-side pointer/flag controller of the async FIFO (read clock domain).
// Optional almost_empty output is compiled in with READ_ALMOST_EMPTY_EN.
module read_logic
  import fifo_pkg::*;
#(
  parameter int unsigned depth    = DEFAULT_DEPTH,
  parameter int unsigned width    = DEFAULT_WIDTH,
  parameter int unsigned ae_level = 4
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        remove,
  input  logic                        flush,
  input  logic [ptr_width(depth)-1:0] w2rsync_ff2,
  output logic [depth-1:0]            read_addr,
  output logic [ptr_width(depth)-1:0] rptr,
  output logic                        read_enable,
  output logic                        rd_valid,
  output logic                        empty,
  output logic                        underflow,
  output logic [ptr_width(depth)-1:0] rcount
`ifdef READ_ALMOST_EMPTY_EN
  ,
  output logic                        almost_empty
`endif
);

  localparam int unsigned PW = ptr_width(depth);

  // Elaboration-time guard against inconsistent sizing.
  if (width == 0 || ae_level > (1 << depth)) begin : g_param_err
    $error("read_logic: invalid width or ae_level");
  end

  fifo_state_e     state_q, state_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [depth-1:0] read_addr_q, read_addr_d;
  logic            read_enable_q, read_enable_d;
  logic            rd_valid_q;
  logic            empty_q, empty_d;
  logic            underflow_q, underflow_d;
  logic [PW-1:0]   rcount_q, rcount_d;
  logic            is_empty_c;
  logic            pop_c;
  logic [PW-1:0]   occ_c;

  fifo_ptr_cmp #(.PW(PW)) u_cmp (
    .ptr_i      (rptr_q),
    .sync_ptr_i (w2rsync_ff2),
    .match_c_o  (is_empty_c),
    .diff_c_o   (occ_c)
  );

  always_comb begin
    state_d       = state_q;
    rptr_d        = rptr_q;
    read_addr_d   = read_addr_q;
    read_enable_d = 1'b0;
    underflow_d   = 1'b0;
    pop_c         = 1'b0;
    case (state_q)
      IDLE: begin
        if (remove) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!remove) begin
          state_d = HOLD;
        end else if (!is_empty_c) begin
          pop_c         = 1'b1;
          read_addr_d   = rptr_q[depth-1:0];
          read_enable_d = 1'b1;
          rptr_d        = rptr_q + PW'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
      HOLD: begin
        if (remove) state_d = ACTIVE;
      end
      default: state_d = IDLE;
    endcase
    // Flags look at the pointer after this cycle's pop.
    rcount_d = occ_c - PW'(pop_c);
    empty_d  = (rcount_d == '0);
  end

  always_ff @(posedge clk_in) begin
    if (reset || flush) begin
      state_q       <= IDLE;
      rptr_q        <= '0;
      read_addr_q   <= '0;
      read_enable_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      empty_q       <= 1'b1;
      underflow_q   <= 1'b0;
      rcount_q      <= '0;
    end else begin
      state_q       <= state_d;
      rptr_q        <= rptr_d;
      read_addr_q   <= read_addr_d;
      read_enable_q <= read_enable_d;
      rd_valid_q    <= read_enable_q;
      empty_q       <= empty_d;
      underflow_q   <= underflow_d;
      rcount_q      <= rcount_d;
    end
  end

`ifdef READ_ALMOST_EMPTY_EN
  logic almost_empty_q;

  always_ff @(posedge clk_in) begin
    if (reset || flush) begin
      almost_empty_q <= 1'b1;
    end else begin
      almost_empty_q <= (rcount_d <= PW'(ae_level));
    end
  end

  assign almost_empty = almost_empty_q;
`endif

  assign read_addr   = read_addr_q;
  assign rptr        = rptr_q;
  assign read_enable = read_enable_q;
  assign rd_valid    = rd_valid_q;
  assign empty       = empty_q;
  assign underflow   = underflow_q;
  assign rcount      = rcount_q;

endmodule

// File: tb/tb_read_logic.sv
// Self-checking bench for read_logic: directed scenarios plus randomized traffic vs a behavioural model.
module tb_read_logic;

  localparam int unsigned DEPTH = 7;
  localparam int unsigned PW    = DEPTH + 1;
  localparam int unsigned AE    = 4;

  logic              clk_in = 1'b0;
  logic              reset = 1'b1;
  logic              remove = 1'b0;
  logic              flush = 1'b0;
  logic [PW-1:0]     w2rsync_ff2 = '0;
  logic [DEPTH-1:0]  read_addr;
  logic [PW-1:0]     rptr;
  logic              read_enable;
  logic              rd_valid;
  logic              empty;
  logic              underflow;
  logic [PW-1:0]     rcount;
`ifdef READ_ALMOST_EMPTY_EN
  logic              almost_empty;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  read_logic #(.depth(DEPTH), .width(8), .ae_level(AE)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .remove      (remove),
    .flush       (flush),
    .w2rsync_ff2 (w2rsync_ff2),
    .read_addr   (read_addr),
    .rptr        (rptr),
    .read_enable (read_enable),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .underflow   (underflow),
    .rcount      (rcount)
`ifdef READ_ALMOST_EMPTY_EN
    ,
    .almost_empty(almost_empty)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pop happens when remove was already high on the previous
  // accepted cycle (the FSM needs one arming cycle) and the FIFO holds data.
  logic             m_valid = 1'b0;
  logic             m_prev_rm;
  logic [PW-1:0]    m_rptr;
  logic [DEPTH-1:0] m_addr;
  logic             m_re, m_rv, m_empty, m_uf, m_ae;
  logic [PW-1:0]    m_cnt;

  always @(posedge clk_in) begin
    if (reset || flush) begin
      m_valid   = 1'b1;
      m_prev_rm = 1'b0;
      m_rptr    = '0;
      m_addr    = '0;
      m_re      = 1'b0;
      m_rv      = 1'b0;
      m_empty   = 1'b1;
      m_uf      = 1'b0;
      m_cnt     = '0;
      m_ae      = 1'b1;
    end else begin
      int occ;
      occ  = int'(PW'(w2rsync_ff2 - m_rptr));
      m_rv = m_re;
      m_re = m_prev_rm && remove && (occ != 0);
      m_uf = m_prev_rm && remove && (occ == 0);
      if (m_re) begin
        m_addr = m_rptr[DEPTH-1:0];
        m_rptr = m_rptr + 1'b1;
        occ    = occ - 1;
      end
      m_cnt     = PW'(occ);
      m_empty   = (occ == 0);
      m_ae      = (occ <= AE);
      m_prev_rm = remove;
    end
  end

  always @(negedge clk_in) begin
    if (m_valid) begin
      check("rptr", 32'(rptr), 32'(m_rptr));
      check("read_addr", 32'(read_addr), 32'(m_addr));
      check("read_enable", 32'(read_enable), 32'(m_re));
      check("rd_valid", 32'(rd_valid), 32'(m_rv));
      check("empty", 32'(empty), 32'(m_empty));
      check("underflow", 32'(underflow), 32'(m_uf));
      check("rcount", 32'(rcount), 32'(m_cnt));
`ifdef READ_ALMOST_EMPTY_EN
      check("almost_empty", 32'(almost_empty), 32'(m_ae));
`endif
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    remove = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  initial begin
    int n_re;
    // Reset/empty
    reset = 1'b1;
    w2rsync_ff2 = '0;
    repeat (2) @(negedge clk_in);
    check("lit_reset_rptr", 32'(rptr), 32'd0);
    check("lit_reset_empty", 32'(empty), 32'd1);
    check("lit_reset_rcount", 32'(rcount), 32'd0);
    check("lit_reset_re", 32'(read_enable), 32'd0);
    reset = 1'b0;
    remove = 1'b1;
    @(negedge clk_in);
    check("lit_uf_c1", 32'(underflow), 32'd0);
    @(negedge clk_in);
    check("lit_uf_c2", 32'(underflow), 32'd1);
    @(negedge clk_in);
    check("lit_uf_c3", 32'(underflow), 32'd1);
    check("lit_uf_rptr", 32'(rptr), 32'd0);
    remove = 1'b0;
    @(negedge clk_in);

    // Single read
    do_reset();
    w2rsync_ff2 = 8'd1;
    remove = 1'b1;
    @(negedge clk_in);
    check("lit_single_arm", 32'(read_enable), 32'd0);
    @(negedge clk_in);
    check("lit_single_re", 32'(read_enable), 32'd1);
    check("lit_single_addr", 32'(read_addr), 32'd0);
    check("lit_single_rptr", 32'(rptr), 32'd1);
    check("lit_single_empty", 32'(empty), 32'd1);
    remove = 1'b0;
    @(negedge clk_in);
    check("lit_single_rv", 32'(rd_valid), 32'd1);
    check("lit_single_re_off", 32'(read_enable), 32'd0);

    // Burst drain of a full FIFO
    do_reset();
    w2rsync_ff2 = 8'd128;
    remove = 1'b1;
    n_re = 0;
    repeat (131) begin
      @(negedge clk_in);
      if (read_enable) n_re++;
    end
    check("lit_burst_count", 32'(n_re), 32'd128);
    check("lit_burst_rptr", 32'(rptr), 32'd128);
    check("lit_burst_empty", 32'(empty), 32'd1);
    check("lit_burst_rcount", 32'(rcount), 32'd0);

    // Wrap-around: walk rptr to 255, then two more entries
    do_reset();
    w2rsync_ff2 = 8'd255;
    remove = 1'b1;
    repeat (257) @(negedge clk_in);
    check("lit_wrap_pre", 32'(rptr), 32'd255);
    w2rsync_ff2 = 8'd1;
    @(negedge clk_in);
    check("lit_wrap_addr0", 32'(read_addr), 32'd127);
    check("lit_wrap_rptr0", 32'(rptr), 32'd0);
    check("lit_wrap_cnt0", 32'(rcount), 32'd1);
    @(negedge clk_in);
    check("lit_wrap_addr1", 32'(read_addr), 32'd0);
    check("lit_wrap_rptr1", 32'(rptr), 32'd1);
    check("lit_wrap_cnt1", 32'(rcount), 32'd0);
    remove = 1'b0;

    // Flush at the 5th pop of 10
    do_reset();
    w2rsync_ff2 = 8'd10;
    remove = 1'b1;
    repeat (5) @(negedge clk_in);
    check("lit_flush_pre", 32'(rptr), 32'd4);
    flush = 1'b1;
    @(negedge clk_in);
    flush = 1'b0;
    check("lit_flush_re", 32'(read_enable), 32'd0);
    check("lit_flush_rptr", 32'(rptr), 32'd0);
    @(negedge clk_in);
    check("lit_flush_arm", 32'(read_enable), 32'd0);
    @(negedge clk_in);
    check("lit_flush_pop", 32'(read_enable), 32'd1);
    check("lit_flush_addr", 32'(read_addr), 32'd0);

    // Randomized traffic
    do_reset();
    w2rsync_ff2 = '0;
    repeat (2000) begin
      int unsigned occ;
      occ = 32'(PW'(w2rsync_ff2 - m_rptr));
      remove = ($urandom_range(0, 9) < 7);
      if (occ < 128 && $urandom_range(0, 2) == 0) w2rsync_ff2 = w2rsync_ff2 + 1'b1;
      flush = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if (flush || reset) w2rsync_ff2 = '0;
      @(negedge clk_in);
    end
    flush = 1'b0;
    reset = 1'b0;
    remove = 1'b0;
    @(negedge clk_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
